// File: rtl/encoder_scan_seq_if.sv
// Handshake bundle for encoder_scan_seq: load/d capture side and
// the o/o_valid/o_ready index stream with busy/done/none status.
interface encoder_scan_seq_if #(
   parameter int N = 8
) ();
   localparam int W = $clog2(N);

   logic         load;
   logic [N-1:0] d;
   logic         o_ready;
   logic [W-1:0] o;
   logic         o_valid;
   logic         busy;
   logic         done;
   logic         none;

   modport master (
      output load, d, o_ready,
      input  o, o_valid, busy, done, none
   );

   modport slave (
      input  load, d, o_ready,
      output o, o_valid, busy, done, none
   );
endinterface

// File: rtl/encoder_scan_seq.sv
// Sequential multi-hot encoder: captures d on load, emits each set bit's index.
// ENCODER_SCAN_MSB_FIRST_EN selects highest-bit-first order (default lowest).
module encoder_scan_seq #(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input logic clk,
   input logic rst,
   encoder_scan_seq_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pend_q, pend_d;
   logic         done_q, done_d;
   logic         none_q, none_d;
   logic [W-1:0] idx;

   // Priority pick: the last match in the loop wins.
   always_comb begin
      idx = '0;
`ifdef ENCODER_SCAN_MSB_FIRST_EN
      for (int i = 0; i < N; i++) begin
         if (pend_q[i]) idx = W'(i);
      end
`else
      for (int i = N - 1; i >= 0; i--) begin
         if (pend_q[i]) idx = W'(i);
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      done_d  = 1'b0;
      none_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.load) begin
               if (bus.d != '0) begin
                  pend_d  = bus.d;
                  state_d = SCAN;
               end else begin
                  done_d = 1'b1;
                  none_d = 1'b1;
               end
            end
         end
         SCAN: begin
            if (bus.o_ready) begin
               pend_d = pend_q & ~(N'(1) << idx);
               if (pend_d == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         done_q  <= 1'b0;
         none_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         none_q  <= none_d;
      end
   end

   assign bus.o_valid = (state_q == SCAN);
   assign bus.busy    = (state_q == SCAN);
   assign bus.o       = (state_q == SCAN) ? idx : '0;
   assign bus.done    = done_q;
   assign bus.none    = none_q;

endmodule

// File: doc/encoder_scan_seq.md
# encoder_scan_seq

Parametrised sequential multi-hot encoder, successor to the 4-to-2 dataflow encoder.
- Captures an N-bit request vector on a load strobe.
- Emits the binary index of every set bit, one index per accepted handshake, in priority order.
- Signals completion with a one-cycle done pulse.
- Sits between request-collection logic and any consumer that services one index at a time, e.g. an interrupt or channel dispatcher.

## Interface
- N, default 8: request vector width; N ≥ 2.
- W, default $clog2(N): index width. Derived; never overridden.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture d when idle.
- d  in  N  request vector.
- o_ready  in  1  consumer accepts current index.
- o  out  W  encoded index of the currently selected set bit; 0 when o_valid=0.
- o_valid  out  1  o holds a valid index.
- busy  out  1  scan in progress; load ignored.
- done  out  1  one-cycle pulse: scan finished.
- none  out  1  one-cycle pulse with done: captured vector was all-zero.

## Operation
- Internal pending register pend[N-1:0], FSM states IDLE and SCAN.
- IDLE (busy=0, o_valid=0):
  - load=1, d≠0: pend←d, go to SCAN.
  - load=1, d=0: stay in IDLE; done=1 and none=1 for the next cycle.
  - load=0: hold.
- SCAN (busy=1, o_valid=1):
  - o = index of the lowest set bit of pend (default order).
  - o_valid=1 and o_ready=1: clear that bit in pend.
  - If it was the last set bit: go to IDLE and pulse done (none=0).
  - o_ready=0: pend, o and o_valid hold unchanged.
- load during SCAN is ignored. d is sampled only on an IDLE load edge.
- Each set bit is emitted exactly once. Number of handshakes = popcount(d).
- Single-hot d reproduces the classic encoder: for N=4, d=4'b0100 gives o=2.
- Reset: pend=0, state=IDLE, o=0, o_valid=0, busy=0, done=0, none=0. Takes effect on the next edge regardless of state, including mid-scan. Remaining pend bits are discarded and no done pulse is produced.
- rst has priority over load and o_ready in the same cycle.

## Timing
- Load-to-first-valid latency: 1 cycle. load sampled at edge k gives o_valid=1 and first o in the cycle after edge k.
- Throughput: one index per cycle while o_ready=1.
- done and none: registered, high for exactly one cycle.
  - After the edge that accepts the final index.
  - Or after the IDLE load edge with d=0.
- busy falls on the same edge done rises. A load in the done cycle is accepted (state is IDLE).
- o and o_valid are functions of registered state only; no combinational path from o_ready or d to outputs.

## Configuration
- ENCODER_SCAN_MSB_FIRST_EN defined: SCAN selects the highest set bit of pend first, emitting indices in descending order.
- Undefined (default): lowest set bit first, ascending order.
- Everything else (latency, handshake, done/none) is identical in both builds.

## Test plan
- Reset: assert rst 2 cycles mid-scan with pend=8'b1010_0000 → next cycle o=0, o_valid=0, busy=0, done=0, none=0. No done pulse follows.
- Full-rate scan, N=8: load d=8'b1001_0010, o_ready=1 → o=1, 4, 7 on three consecutive cycles with o_valid=1. done=1 in the following cycle, busy=0.
- Backpressure: same d, o_ready=0 for 3 cycles after first valid → o holds 1, o_valid holds 1. After o_ready=1, sequence continues 4, 7.
- Empty and ignored loads:
  - load d=0 → done=1, none=1 for one cycle; busy and o_valid never rise.
  - load d=8'hFF while busy → ignored; current scan sequence unchanged.
- N=4 single-hot: d=4'b0001, 4'b0010, 4'b0100, 4'b1000, each loaded and drained → o=0, 1, 2, 3 respectively; one done per load.
- With ENCODER_SCAN_MSB_FIRST_EN: load d=8'b1001_0010 → o=7, 4, 1, then done.
